axiline_seq_ctrl: RTL

- Sequencer for one accelerator-wrapper job.
- Accepts a 32-bit host word stream and writes it into the input-x BRAM and then the weight BRAM.
- Pulses start to the accelerator, times the compute window, and commits the result vector into the output BRAMs.
- Drains the output BRAMs to the host as 64-bit words under a valid/ready handshake.
- Sits between the host/AXI-lite shim and the wrapper's addr/addr_out/wea/data_in_mem/start/r_w/data_out pins.

---
 rtl/axiline_ctrl_pkg.sv | 17 +
 rtl/axiline_out_drain.sv | 87 ++++++++
 rtl/axiline_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/axiline_ctrl_pkg.sv
// Shared types and constants for the axiline job sequencer and its output drain.
package axiline_ctrl_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] WEA_X = 2'b01;
  localparam logic [1:0] WEA_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE, LOAD_X, LOAD_W, START, RUN, COMMIT, DRAIN
  } seq_state_e;

  typedef enum logic [1:0] {
    D_IDLE, D_ADDR, D_LAT, D_HOLD
  } drain_state_e;

endpackage

// File: rtl/axiline_out_drain.sv
// Output drain: walks the result BRAM, absorbs the one-cycle read latency and
// holds each 64-bit word on a valid/ready handshake until the host takes it.
//
// state  | meaning
// D_IDLE | waiting for start pulse, out_addr parked at 0
// D_ADDR | read address on the BRAM pins
// D_LAT  | BRAM read latency; data captured at the end of this cycle
// D_HOLD | out_valid high, word held until out_ready
module axiline_out_drain
  import axiline_ctrl_pkg::*;
#(
  parameter int OUT_WORDS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_out_ready,
  input  logic [63:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_out_addr,
  output logic             o_out_valid,
  output logic [63:0]      o_out_data,
  output logic             o_last_accept
);

  drain_state_e     r_state, w_nxt_state;
  logic [CNT_W-1:0] r_ocnt, w_nxt_ocnt;
  logic [CNT_W-1:0] r_addr, w_nxt_addr;
  logic [63:0]      r_data, w_nxt_data;
  logic             w_accept;

  assign w_accept      = (r_state == D_HOLD) && i_out_ready;
  assign o_last_accept = w_accept && (r_ocnt == CNT_W'(OUT_WORDS - 1));
  assign o_out_valid   = (r_state == D_HOLD);
  assign o_out_addr    = r_addr;
  assign o_out_data    = r_data;

  // Next-state: issue address, wait out read latency, hold word until accepted.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ocnt  = r_ocnt;
    w_nxt_addr  = r_addr;
    w_nxt_data  = r_data;
    case (r_state)
      D_IDLE: begin
        if (i_start) begin
          w_nxt_state = D_ADDR;
          w_nxt_ocnt  = '0;
          w_nxt_addr  = '0;
        end
      end
      D_ADDR: w_nxt_state = D_LAT;
      D_LAT: begin
        w_nxt_data  = i_mem_rdata;
        w_nxt_state = D_HOLD;
      end
      D_HOLD: begin
        if (o_last_accept) begin
          // Park the address at 0 so the next COMMIT sees out_addr=0.
          w_nxt_state = D_IDLE;
          w_nxt_ocnt  = '0;
          w_nxt_addr  = '0;
        end else if (w_accept) begin
          w_nxt_state = D_ADDR;
          w_nxt_ocnt  = r_ocnt + CNT_W'(1);
          w_nxt_addr  = r_ocnt + CNT_W'(1);
        end
      end
      default: w_nxt_state = D_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= D_IDLE;
      r_ocnt  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ocnt  <= w_nxt_ocnt;
      r_addr  <= w_nxt_addr;
      r_data  <= w_nxt_data;
    end
  end

endmodule

// File: rtl/axiline_seq_ctrl.sv
// Job sequencer for the axiline accelerator wrapper: loads x then w BRAMs from
// the host stream, pulses start, times the compute window, commits and drains.
//
// state  | meaning
// IDLE   | waiting for go
// LOAD_X | accepting host words into the x BRAM
// LOAD_W | accepting host words into the w BRAM
// START  | one settle cycle, then one-cycle acc_start
// RUN    | counting the compute window
// COMMIT | one-cycle out_we with out_addr=0
// DRAIN  | result words handed to the host by axiline_out_drain
module axiline_seq_ctrl
  import axiline_ctrl_pkg::*;
#(
  parameter int X_WORDS    = 32,
  parameter int W_WORDS    = 32,
  parameter int RUN_CYCLES = 64,
  parameter int OUT_WORDS  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  output logic [CNT_W-1:0] o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic [1:0]       o_mem_wea,
  output logic             o_acc_start,
  output logic [CNT_W-1:0] o_out_addr,
  output logic             o_out_we,
  input  logic [63:0]      i_mem_rdata,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [63:0]      o_out_data,
  output logic             o_busy,
  output logic             o_done
);

  seq_state_e       r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [CNT_W-1:0] r_cyc, w_nxt_cyc;
  logic [CNT_W-1:0] r_mem_addr, w_nxt_mem_addr;
  logic [31:0]      r_mem_wdata, w_nxt_mem_wdata;
  logic [1:0]       r_mem_wea, w_nxt_mem_wea;
  logic             r_acc_start, w_nxt_acc_start;
  logic             r_out_we, w_nxt_out_we;
  logic             r_busy, w_nxt_busy;
  logic             r_done, w_nxt_done;
  logic             w_take;
  logic             w_drain_start;
  logic             w_last_accept;

  assign o_in_ready    = (r_state == LOAD_X) || (r_state == LOAD_W);
  assign w_take        = i_in_valid && o_in_ready;
  assign w_drain_start = (r_state == COMMIT);

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wea   = r_mem_wea;
  assign o_acc_start = r_acc_start;
  assign o_out_we    = r_out_we;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  axiline_out_drain #(.OUT_WORDS(OUT_WORDS)) u_drain (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (w_drain_start),
    .i_out_ready   (i_out_ready),
    .i_mem_rdata   (i_mem_rdata),
    .o_out_addr    (o_out_addr),
    .o_out_valid   (o_out_valid),
    .o_out_data    (o_out_data),
    .o_last_accept (w_last_accept)
  );

  // Next-state and next-output decode; pulses default low, bus values hold.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_cyc       = r_cyc;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_wdata = r_mem_wdata;
    w_nxt_mem_wea   = '0;
    w_nxt_acc_start = 1'b0;
    w_nxt_out_we    = 1'b0;
    w_nxt_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_go) begin
          w_nxt_state = LOAD_X;
          w_nxt_cnt   = '0;
        end
      end
      LOAD_X: begin
        if (w_take) begin
          w_nxt_mem_wea   = WEA_X;
          w_nxt_mem_addr  = r_cnt;
          w_nxt_mem_wdata = i_in_data;
          if (r_cnt == CNT_W'(X_WORDS - 1)) begin
            w_nxt_state = LOAD_W;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      LOAD_W: begin
        if (w_take) begin
          w_nxt_mem_wea   = WEA_W;
          w_nxt_mem_addr  = r_cnt;
          w_nxt_mem_wdata = i_in_data;
          if (r_cnt == CNT_W'(W_WORDS - 1)) begin
            w_nxt_state = START;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      START: begin
        // r_cnt doubles as the settle flag so the last w write lands first.
        if (r_cnt == '0) begin
          w_nxt_cnt = CNT_W'(1);
        end else begin
          w_nxt_acc_start = 1'b1;
          w_nxt_mem_addr  = '0;
          w_nxt_cnt       = '0;
          w_nxt_cyc       = '0;
          w_nxt_state     = RUN;
        end
      end
      RUN: begin
        if (r_cyc == CNT_W'(RUN_CYCLES - 1)) begin
          w_nxt_state  = COMMIT;
          w_nxt_out_we = 1'b1;
        end else begin
          w_nxt_cyc = r_cyc + CNT_W'(1);
        end
      end
      COMMIT: w_nxt_state = DRAIN;
      DRAIN: begin
        if (w_last_accept) begin
          w_nxt_state = IDLE;
          w_nxt_done  = 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
    w_nxt_busy = (w_nxt_state != IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cyc       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wea   <= '0;
      r_acc_start <= 1'b0;
      r_out_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_cyc       <= w_nxt_cyc;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
      r_mem_wea   <= w_nxt_mem_wea;
      r_acc_start <= w_nxt_acc_start;
      r_out_we    <= w_nxt_out_we;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
    end
  end

endmodule
